video_timing_gen: RTL and testbench



---
 rtl/video_timing_pkg.sv | 51 +++++
 rtl/video_timing_gen_if.sv | 28 ++
 rtl/video_timing_lut.sv | 19 +
 rtl/video_timing_gen.sv | 123 ++++++++++++
 tb/tb_video_timing_gen.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_timing_pkg.sv
// Shared definitions for the HDMI-side video timing generator: mode encoding,
// the timing-table record and the three supported timing tables.
package video_timing_pkg;

  typedef enum logic [1:0] {
    MODE_NTSC = 2'd0,
    MODE_PAL  = 2'd1,
    MODE_MONO = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef struct packed {
    logic [10:0] h_total;
    logic [10:0] h_active;
    logic [10:0] hs_start;
    logic [10:0] hs_width;
    logic [9:0]  v_total;
    logic [9:0]  v_active;
    logic [9:0]  vs_start;
    logic [9:0]  vs_width;
  } timing_t;

  localparam timing_t TIMING_NTSC = '{
    h_total: 11'd858, h_active: 11'd720, hs_start: 11'd736, hs_width: 11'd62,
    v_total: 10'd525, v_active: 10'd480, vs_start: 10'd489, vs_width: 10'd6
  };

  localparam timing_t TIMING_PAL = '{
    h_total: 11'd864, h_active: 11'd720, hs_start: 11'd732, hs_width: 11'd64,
    v_total: 10'd625, v_active: 10'd576, vs_start: 10'd581, vs_width: 10'd5
  };

  localparam timing_t TIMING_MONO = '{
    h_total: 11'd800, h_active: 11'd640, hs_start: 11'd656, hs_width: 11'd96,
    v_total: 10'd449, v_active: 10'd400, vs_start: 10'd412, vs_width: 10'd2
  };

  // The reserved encoding behaves as NTSC everywhere, so fold it early; this
  // keeps a 0<->3 toggle from looking like a geometry change.
  function automatic mode_e norm_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_NTSC : mode_e'(m);
  endfunction

  // Resync offsets must land inside the frame of the mode being entered.
  function automatic int clamp_off(input int off, input int total);
    if (off < 0) return 0;
    if (off > total - 1) return total - 1;
    return off;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Bundle between the video analyzer / HDMI encoder side and the timing
// generator. The frame_cnt signal exists only when VIDEO_TIMING_FRAME_CNT_EN
// is defined.
interface video_timing_gen_if;

  logic [1:0]  mode;
  logic        vreset;
  logic [10:0] hcnt;
  logic [9:0]  vcnt;
  logic        hs;
  logic        vs;
  logic        de;
  logic        locked;
`ifdef VIDEO_TIMING_FRAME_CNT_EN
  logic [7:0]  frame_cnt;

  modport master (input mode, vreset,
                  output hcnt, vcnt, hs, vs, de, locked, frame_cnt);
  modport slave  (output mode, vreset,
                  input hcnt, vcnt, hs, vs, de, locked, frame_cnt);
`else
  modport master (input mode, vreset,
                  output hcnt, vcnt, hs, vs, de, locked);
  modport slave  (output mode, vreset,
                  input hcnt, vcnt, hs, vs, de, locked);
`endif

endinterface

// File: rtl/video_timing_lut.sv
// Combinational mode -> timing table lookup. The reserved mode maps to NTSC.
module video_timing_lut
  import video_timing_pkg::*;
(
  input  mode_e   mode,
  output timing_t timing
);

  // Table select; anything not PAL or mono falls back to NTSC.
  always_comb begin
    timing = TIMING_NTSC;
    case (mode)
      MODE_PAL:  timing = TIMING_PAL;
      MODE_MONO: timing = TIMING_MONO;
      default:   timing = TIMING_NTSC;
    endcase
  end

endmodule

// File: rtl/video_timing_gen.sv
// Free-running HDMI video timing generator. Counts pixels/lines for the
// active mode, latches mode changes only at frame boundaries, and jumps to
// (HOFFS, VOFFS) on a vreset pulse to stay phase-locked to the source.
// Optional frame counter output: define VIDEO_TIMING_FRAME_CNT_EN.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int HOFFS = 0,
  parameter int VOFFS = 0
) (
  input logic                clk,
  input logic                resetn,
  video_timing_gen_if.master vif
);

  // Offsets are elaboration constants, so clamp them per mode up front.
  localparam logic [10:0] HOFF_NTSC = 11'(clamp_off(HOFFS, int'(TIMING_NTSC.h_total)));
  localparam logic [10:0] HOFF_PAL  = 11'(clamp_off(HOFFS, int'(TIMING_PAL.h_total)));
  localparam logic [10:0] HOFF_MONO = 11'(clamp_off(HOFFS, int'(TIMING_MONO.h_total)));
  localparam logic [9:0]  VOFF_NTSC = 10'(clamp_off(VOFFS, int'(TIMING_NTSC.v_total)));
  localparam logic [9:0]  VOFF_PAL  = 10'(clamp_off(VOFFS, int'(TIMING_PAL.v_total)));
  localparam logic [9:0]  VOFF_MONO = 10'(clamp_off(VOFFS, int'(TIMING_MONO.v_total)));

  mode_e       act_q, act_d;
  mode_e       pend_q, pend_d;
  mode_e       mode_in;
  logic [10:0] hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        de_q, de_d;
  logic        locked_q, locked_d;
  logic        h_wrap, v_last, f_wrap;
  timing_t     tm;

  video_timing_lut u_lut (
    .mode   (act_q),
    .timing (tm)
  );

  assign mode_in = norm_mode(vif.mode);
  assign h_wrap  = (hcnt_q == tm.h_total - 11'd1);
  assign v_last  = (vcnt_q == tm.v_total - 10'd1);
  assign f_wrap  = h_wrap && v_last;

  // Counter advance, mode latching, lock tracking and registered sync/DE.
  always_comb begin
    hcnt_d   = h_wrap ? 11'd0 : hcnt_q + 11'd1;
    vcnt_d   = vcnt_q;
    act_d    = act_q;
    pend_d   = mode_in;
    locked_d = locked_q;
    if (h_wrap) vcnt_d = v_last ? 10'd0 : vcnt_q + 10'd1;

    if (vif.vreset) begin
      // Take the live mode so a change arriving with the pulse is not lost.
      act_d    = mode_in;
      locked_d = 1'b1;
      case (mode_in)
        MODE_PAL:  begin hcnt_d = HOFF_PAL;  vcnt_d = VOFF_PAL;  end
        MODE_MONO: begin hcnt_d = HOFF_MONO; vcnt_d = VOFF_MONO; end
        default:   begin hcnt_d = HOFF_NTSC; vcnt_d = VOFF_NTSC; end
      endcase
    end else if (f_wrap) begin
      act_d = pend_q;
      if (pend_q != act_q) locked_d = 1'b0;
    end

    de_d = (hcnt_q < tm.h_active) && (vcnt_q < tm.v_active);
    hs_d = !((hcnt_q >= tm.hs_start) && (hcnt_q < tm.hs_start + tm.hs_width));
    vs_d = !((vcnt_q >= tm.vs_start) && (vcnt_q < tm.vs_start + tm.vs_width));
  end

  // State registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      act_q    <= MODE_NTSC;
      pend_q   <= MODE_NTSC;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      de_q     <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      act_q    <= act_d;
      pend_q   <= pend_d;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      de_q     <= de_d;
      locked_q <= locked_d;
    end
  end

  assign vif.hcnt   = hcnt_q;
  assign vif.vcnt   = vcnt_q;
  assign vif.hs     = hs_q;
  assign vif.vs     = vs_q;
  assign vif.de     = de_q;
  assign vif.locked = locked_q;

`ifdef VIDEO_TIMING_FRAME_CNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  // Frame counter: cleared by resync, otherwise counts frame wraps mod 256.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (vif.vreset)  frame_cnt_d = 8'd0;
    else if (f_wrap) frame_cnt_d = frame_cnt_q + 8'd1;
  end

  // Frame counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) frame_cnt_q <= 8'd0;
    else         frame_cnt_q <= frame_cnt_d;
  end

  assign vif.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen. Two instances: one with zero offsets, one with
// offsets close to the frame end (and beyond the mono/NTSC totals) so frame
// wraps and offset clamping are reachable in a short run.
module tb_video_timing_gen;

  localparam int HOFF1 = 850;
  localparam int VOFF1 = 620;
  localparam logic [24:0] RESET_VEC = {11'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};

  logic       clk = 1'b0;
  logic       resetn;
  logic [1:0] mode_drv;
  logic       vr0, vr1;
  int         n_checks = 0;
  int         n_fail = 0;

  video_timing_gen_if if0 ();
  video_timing_gen_if if1 ();

  assign if0.mode   = mode_drv;
  assign if1.mode   = mode_drv;
  assign if0.vreset = vr0;
  assign if1.vreset = vr1;

  video_timing_gen #(.HOFFS(0), .VOFFS(0)) dut0 (.clk(clk), .resetn(resetn), .vif(if0));
  video_timing_gen #(.HOFFS(HOFF1), .VOFFS(VOFF1)) dut1 (.clk(clk), .resetn(resetn), .vif(if1));

  always #5 clk = ~clk;

  // Timing tables indexed by mode (0 NTSC, 1 PAL, 2 mono).
  int HT  [3] = '{858, 864, 800};
  int HA  [3] = '{720, 720, 640};
  int HSS [3] = '{736, 732, 656};
  int HSW [3] = '{62, 64, 96};
  int VT  [3] = '{525, 625, 449};
  int VA  [3] = '{480, 576, 400};
  int VSS [3] = '{489, 581, 412};
  int VSW [3] = '{6, 5, 2};
  int OFFH[2] = '{0, HOFF1};
  int OFFV[2] = '{0, VOFF1};

  // Reference model: position kept as (line, pixel) but advanced as a linear
  // index into the frame.
  int m_h[2], m_v[2], m_act[2], m_pend[2], m_fc[2];
  bit m_hs[2], m_vs[2], m_de[2], m_lock[2];
  int ma, mnm, mpos;
  bit mvr, mfw;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < 2; k++) begin
        m_h[k] = 0; m_v[k] = 0; m_act[k] = 0; m_pend[k] = 0; m_fc[k] = 0;
        m_hs[k] = 1; m_vs[k] = 1; m_de[k] = 0; m_lock[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        ma  = m_act[k];
        mnm = (mode_drv == 2'd3) ? 0 : int'(mode_drv);
        mvr = (k == 0) ? vr0 : vr1;
        m_de[k] = (m_h[k] < HA[ma]) && (m_v[k] < VA[ma]);
        m_hs[k] = !((m_h[k] >= HSS[ma]) && (m_h[k] < HSS[ma] + HSW[ma]));
        m_vs[k] = !((m_v[k] >= VSS[ma]) && (m_v[k] < VSS[ma] + VSW[ma]));
        mpos = m_v[k] * HT[ma] + m_h[k] + 1;
        mfw  = (mpos == HT[ma] * VT[ma]);
        if (mvr) begin
          m_act[k]  = mnm;
          m_h[k]    = (OFFH[k] > HT[mnm] - 1) ? HT[mnm] - 1 : OFFH[k];
          m_v[k]    = (OFFV[k] > VT[mnm] - 1) ? VT[mnm] - 1 : OFFV[k];
          m_lock[k] = 1;
          m_fc[k]   = 0;
        end else begin
          if (mfw) begin
            mpos = 0;
            if (m_pend[k] != ma) m_lock[k] = 0;
            m_act[k] = m_pend[k];
            m_fc[k]  = (m_fc[k] + 1) % 256;
          end
          m_h[k] = mpos % HT[ma];
          m_v[k] = mpos / HT[ma];
        end
        m_pend[k] = mnm;
      end
    end
  end

  function automatic logic [24:0] dut_vec(input int k);
    if (k == 0) return {if0.hcnt, if0.vcnt, if0.hs, if0.vs, if0.de, if0.locked};
    return {if1.hcnt, if1.vcnt, if1.hs, if1.vs, if1.de, if1.locked};
  endfunction

  function automatic logic [24:0] mdl_vec(input int k);
    return {11'(m_h[k]), 10'(m_v[k]), m_hs[k], m_vs[k], m_de[k], m_lock[k]};
  endfunction

  task automatic test_reset();
    resetn = 1'b0; mode_drv = 2'd0; vr0 = 1'b0; vr1 = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (dut_vec(k) !== RESET_VEC) begin
        n_fail++;
        $display("FAIL reset inst%0d: got h/v/hs/vs/de/lk=%h, want %h", k, dut_vec(k), RESET_VEC);
      end
    end
  endtask

  // PAL requested without resync: the first frame must keep NTSC geometry.
  task automatic test_freerun_mode_hold();
    int de_cnt = 0, hs_cnt = 0;
    mode_drv = 2'd1;
    resetn = 1'b1;
    for (int i = 1; i <= 4 * 858; i++) begin
      @(negedge clk);
      if (if0.de) de_cnt++;
      if (!if0.hs) hs_cnt++;
      if (i == 858) begin
        n_checks++;
        if (if0.hcnt !== 11'd0 || if0.vcnt !== 10'd1) begin
          n_fail++;
          $display("FAIL freerun_line_len: got h=%0d v=%0d, want h=0 v=1", if0.hcnt, if0.vcnt);
        end
      end
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (dut_vec(k) !== mdl_vec(k)) begin
          n_fail++;
          $display("FAIL freerun inst%0d cyc%0d: got %h, want %h", k, i, dut_vec(k), mdl_vec(k));
        end
      end
    end
    n_checks++;
    if (de_cnt != 4 * 720) begin
      n_fail++; $display("FAIL freerun_de_count: got %0d, want %0d", de_cnt, 4 * 720);
    end
    n_checks++;
    if (hs_cnt != 4 * 62) begin
      n_fail++; $display("FAIL freerun_hs_count: got %0d, want %0d", hs_cnt, 4 * 62);
    end
    n_checks++;
    if (if0.locked !== 1'b0) begin
      n_fail++; $display("FAIL freerun_locked: got %b, want 0", if0.locked);
    end
  endtask

  task automatic test_resync();
    bit found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (if0.hcnt == 11'd300) found = 1;
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL resync_wait: hcnt=%0d, want 300 within bound", if0.hcnt);
      return;
    end
    vr0 = 1'b1;
    @(negedge clk);
    vr0 = 1'b0;
    n_checks++;
    if (if0.hcnt !== 11'd0 || if0.vcnt !== 10'd0 || if0.locked !== 1'b1) begin
      n_fail++;
      $display("FAIL resync_load: got h=%0d v=%0d lk=%b, want h=0 v=0 lk=1", if0.hcnt, if0.vcnt, if0.locked);
    end
    @(negedge clk);
    n_checks++;
    if (if0.de !== 1'b1) begin
      n_fail++; $display("FAIL resync_de: got %b, want 1", if0.de);
    end
  endtask

  // Mono offsets exceed the table, so both must clamp to total-1.
  task automatic test_clamp();
    mode_drv = 2'd2; vr1 = 1'b1;
    @(negedge clk);
    vr1 = 1'b0;
    n_checks++;
    if (if1.hcnt !== 11'd799 || if1.vcnt !== 10'd448 || if1.locked !== 1'b1) begin
      n_fail++;
      $display("FAIL clamp_load: got h=%0d v=%0d lk=%b, want h=799 v=448 lk=1", if1.hcnt, if1.vcnt, if1.locked);
    end
    @(negedge clk);
    n_checks++;
    if (if1.hcnt !== 11'd0 || if1.vcnt !== 10'd0 || if1.locked !== 1'b1) begin
      n_fail++;
      $display("FAIL clamp_wrap: got h=%0d v=%0d lk=%b, want h=0 v=0 lk=1", if1.hcnt, if1.vcnt, if1.locked);
    end
    for (int i = 0; i < 810; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (dut_vec(k) !== mdl_vec(k)) begin
          n_fail++;
          $display("FAIL clamp_run inst%0d cyc%0d: got %h, want %h", k, i, dut_vec(k), mdl_vec(k));
        end
      end
    end
  endtask

  // Mid-frame switch to PAL: NTSC frame completes, PAL follows, lock drops.
  task automatic test_mode_change();
    mode_drv = 2'd0; vr1 = 1'b1;
    @(negedge clk);
    vr1 = 1'b0; mode_drv = 2'd1;
    n_checks++;
    if (if1.hcnt !== 11'd850 || if1.vcnt !== 10'd524 || if1.locked !== 1'b1) begin
      n_fail++;
      $display("FAIL modechg_load: got h=%0d v=%0d lk=%b, want h=850 v=524 lk=1", if1.hcnt, if1.vcnt, if1.locked);
    end
    for (int i = 1; i <= 8 + 864; i++) begin
      @(negedge clk);
      if (i == 7) begin
        n_checks++;
        if (if1.hcnt !== 11'd857 || if1.locked !== 1'b1) begin
          n_fail++; $display("FAIL modechg_ntsc_end: got h=%0d lk=%b, want h=857 lk=1", if1.hcnt, if1.locked);
        end
      end
      if (i == 8) begin
        n_checks++;
        if (if1.hcnt !== 11'd0 || if1.vcnt !== 10'd0 || if1.locked !== 1'b0) begin
          n_fail++;
          $display("FAIL modechg_wrap: got h=%0d v=%0d lk=%b, want h=0 v=0 lk=0", if1.hcnt, if1.vcnt, if1.locked);
        end
      end
      if (i == 8 + 863) begin
        n_checks++;
        if (if1.hcnt !== 11'd863 || if1.vcnt !== 10'd0) begin
          n_fail++; $display("FAIL modechg_pal_len: got h=%0d v=%0d, want h=863 v=0", if1.hcnt, if1.vcnt);
        end
      end
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (dut_vec(k) !== mdl_vec(k)) begin
          n_fail++;
          $display("FAIL modechg_run inst%0d cyc%0d: got %h, want %h", k, i, dut_vec(k), mdl_vec(k));
        end
      end
    end
  endtask

  // vreset on the exact frame-wrap cycle together with a change to mono.
  task automatic test_simultaneous();
    bit found = 0;
    mode_drv = 2'd0; vr1 = 1'b1;
    @(negedge clk);
    vr1 = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (if1.hcnt == 11'd857 && if1.vcnt == 10'd524) found = 1;
      else @(negedge clk);
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL simul_wait: h=%0d v=%0d, want 857/524 within bound", if1.hcnt, if1.vcnt);
      return;
    end
    mode_drv = 2'd2; vr1 = 1'b1;
    @(negedge clk);
    vr1 = 1'b0;
    n_checks++;
    if (if1.hcnt !== 11'd799 || if1.vcnt !== 10'd448 || if1.locked !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_load: got h=%0d v=%0d lk=%b, want h=799 v=448 lk=1", if1.hcnt, if1.vcnt, if1.locked);
    end
    @(negedge clk);
    n_checks++;
    if (if1.hcnt !== 11'd0 || if1.vcnt !== 10'd0 || if1.locked !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_mono_wrap: got h=%0d v=%0d lk=%b, want h=0 v=0 lk=1", if1.hcnt, if1.vcnt, if1.locked);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (dut_vec(k) !== mdl_vec(k)) begin
          n_fail++;
          $display("FAIL random inst%0d cyc%0d: got %h, want %h", k, c, dut_vec(k), mdl_vec(k));
        end
      end
      vr0 = ($urandom_range(0, 699) == 0);
      vr1 = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 399) == 0) mode_drv = 2'($urandom_range(0, 3));
    end
    @(negedge clk);
    vr0 = 1'b0; vr1 = 1'b0;
  endtask

`ifdef VIDEO_TIMING_FRAME_CNT_EN
  task automatic test_frame_cnt();
    mode_drv = 2'd0; vr1 = 1'b1;
    @(negedge clk);
    vr1 = 1'b0;
    n_checks++;
    if (if1.frame_cnt !== 8'd0) begin
      n_fail++; $display("FAIL fcnt_clear: got %0d, want 0", if1.frame_cnt);
    end
    repeat (8) @(negedge clk);
    n_checks++;
    if (if1.frame_cnt !== 8'd1 || if1.frame_cnt !== 8'(m_fc[1])) begin
      n_fail++; $display("FAIL fcnt_incr: got %0d, want 1", if1.frame_cnt);
    end
    vr1 = 1'b1;
    @(negedge clk);
    vr1 = 1'b0;
    n_checks++;
    if (if1.frame_cnt !== 8'd0) begin
      n_fail++; $display("FAIL fcnt_vreset: got %0d, want 0", if1.frame_cnt);
    end
  endtask
`endif

  // Asynchronous reset mid-line, then restart from 0 in NTSC.
  task automatic test_async_reset();
    bit found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (if0.hcnt == 11'd500) found = 1;
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL areset_wait: hcnt=%0d, want 500 within bound", if0.hcnt);
      return;
    end
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (dut_vec(k) !== RESET_VEC) begin
        n_fail++; $display("FAIL areset_now inst%0d: got %h, want %h", k, dut_vec(k), RESET_VEC);
      end
    end
    @(negedge clk);
    mode_drv = 2'd0; vr0 = 1'b0; vr1 = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (if0.hcnt !== 11'(i) || if0.vcnt !== 10'd0 || if0.locked !== 1'b0) begin
        n_fail++;
        $display("FAIL areset_restart cyc%0d: got h=%0d v=%0d lk=%b, want h=%0d v=0 lk=0",
                 i, if0.hcnt, if0.vcnt, if0.locked, i);
      end
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (dut_vec(k) !== mdl_vec(k)) begin
          n_fail++;
          $display("FAIL areset_run inst%0d cyc%0d: got %h, want %h", k, i, dut_vec(k), mdl_vec(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_freerun_mode_hold();
    test_resync();
    test_clamp();
    test_mode_change();
    test_simultaneous();
    test_random();
`ifdef VIDEO_TIMING_FRAME_CNT_EN
    test_frame_cnt();
`endif
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
